// File: rtl/fetch_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_param
// Purpose  : Instruction-fetch stage. Holds the PC, forms PC+PC_INC, redirects
//            to a branch target and registers the fetched instruction into the
//            IF/ID pipeline register. IF/ID supports stall, flush, a valid bit,
//            decoded field slices and a saturating count of valid captures.
// Ports    : clk_i            clock, rising edge
//            reset_i          synchronous reset, active low
//            pc_enable_i      PC may advance (0 = PC stall)
//            ifid_enable_i    IF/ID may capture (0 = IF/ID stall)
//            branch_taken_i   redirect PC to branch_target_i
//            branch_target_i  branch target address
//            flush_i          squash IF/ID to NOP
//            imem_data_i      instruction read combinationally at imem_addr_o
//            imem_addr_o      instruction memory address (= pc_o)
//            pc_o / next_pc_o current PC / PC + PC_INC
//            id_*_o           IF/ID instruction, next PC, valid and fields
//            fetch_count_o    number of valid instructions captured
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage_param #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_INC     = 4,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pc_enable_i,
  input  logic              ifid_enable_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0] id_next_pc_o,
  output logic              id_valid_o,
  output logic [3:0]        id_cond_o,
  output logic [3:0]        id_rn_o,
  output logic [3:0]        id_rd_o,
  output logic [3:0]        id_rm_o,
  output logic [11:0]       id_imm12_o,
  output logic [23:0]       id_imm24_o,
  output logic [CNT_W-1:0]  fetch_count_o
);

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_pc_inc   = ADDR_W'(PC_INC);
  localparam logic              c_squash_on_branch = (DELAY_SLOT == 0);

  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic [DATA_W-1:0] id_instr_q,   id_instr_d;
  logic [ADDR_W-1:0] id_next_pc_q, id_next_pc_d;
  logic              id_valid_q,   id_valid_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic [ADDR_W-1:0] w_next_pc;
  logic              w_squash;
  logic              w_capture;

  // Sum is truncated to ADDR_W, so the PC wraps silently at the top.
  assign w_next_pc = pc_q + c_pc_inc;

  // Without a delay slot the instruction fetched alongside a taken branch is
  // on the wrong path and must not reach decode.
  assign w_squash  = flush_i | (branch_taken_i & c_squash_on_branch);
  assign w_capture = ~w_squash & ifid_enable_i;

  always_comb begin
    pc_d         = pc_q;
    id_instr_d   = id_instr_q;
    id_next_pc_d = id_next_pc_q;
    id_valid_d   = id_valid_q;
    cnt_d        = cnt_q;

    // A resolved branch is honoured even while the PC is stalled.
    if (branch_taken_i) begin
      pc_d = branch_target_i;
    end else if (pc_enable_i) begin
      pc_d = w_next_pc;
    end

    if (w_squash) begin
      id_instr_d   = '0;
      id_next_pc_d = '0;
      id_valid_d   = 1'b0;
    end else if (ifid_enable_i) begin
      id_instr_d   = imem_data_i;
      id_next_pc_d = w_next_pc;
      id_valid_d   = 1'b1;
    end

    // Re-captures during a PC stall count too; the counter sticks at all-ones.
    if (w_capture && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc_q         <= c_reset_pc;
      id_instr_q   <= '0;
      id_next_pc_q <= '0;
      id_valid_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      id_instr_q   <= id_instr_d;
      id_next_pc_q <= id_next_pc_d;
      id_valid_q   <= id_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign next_pc_o     = w_next_pc;
  assign id_instr_o    = id_instr_q;
  assign id_next_pc_o  = id_next_pc_q;
  assign id_valid_o    = id_valid_q;
  assign fetch_count_o = cnt_q;

  assign id_cond_o  = id_instr_q[31:28];
  assign id_rn_o    = id_instr_q[19:16];
  assign id_rd_o    = id_instr_q[15:12];
  assign id_rm_o    = id_instr_q[3:0];
  assign id_imm12_o = id_instr_q[11:0];
  assign id_imm24_o = id_instr_q[23:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage_param
// Purpose  : Self-checking bench for fetch_stage_param. Three instances share
//            the stimulus: a default one (delay slot on), one with the delay
//            slot off, and an 8-bit-address one with a 2-bit fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage_param;

  typedef struct {
    bit          rst_n, pe, ie, br, fl;
    logic [31:0] tgt;
    // expected state after the edge (delay-slot instance / 8-bit instance)
    logic [31:0] e_pc;
    bit          e_v;
    int          e_idx;   // word index into memory, -1 means NOP (0)
    logic [31:0] e_np;
    int          e_cnt;
    // expected IF/ID state of the no-delay-slot instance
    bit          d_v;
    int          d_idx;
    logic [31:0] d_np;
    int          d_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, pe = 1'b0, ie = 1'b0, br = 1'b0, fl = 1'b0;
  logic [31:0] tgt = '0;

  int total = 0;
  int bad   = 0;
  vec_t q[$];

  function automatic logic [31:0] mem_word(input logic [7:0] i);
    logic [7:0] a, b, c;
    a = i * 8'd3;
    b = i ^ 8'h5A;
    c = i + 8'd1;
    return {i[3:0], 4'hA, a, b, c};
  endfunction

  function automatic logic [31:0] word_of(input int idx);
    return (idx < 0) ? 32'h0 : mem_word(8'(idx));
  endfunction

  // ---------------- default instance (DELAY_SLOT = 1) ----------------
  logic [31:0] m_addr, m_pc, m_npc, m_instr, m_idnp, m_data;
  logic        m_v;
  logic [3:0]  m_cond, m_rn, m_rd, m_rm;
  logic [11:0] m_i12;
  logic [23:0] m_i24;
  logic [15:0] m_cnt;
  assign m_data = mem_word(m_addr[9:2]);

  fetch_stage_param u_main (
    .clk_i(clk), .reset_i(rst_n), .pc_enable_i(pe), .ifid_enable_i(ie),
    .branch_taken_i(br), .branch_target_i(tgt), .flush_i(fl),
    .imem_data_i(m_data), .imem_addr_o(m_addr), .pc_o(m_pc), .next_pc_o(m_npc),
    .id_instr_o(m_instr), .id_next_pc_o(m_idnp), .id_valid_o(m_v),
    .id_cond_o(m_cond), .id_rn_o(m_rn), .id_rd_o(m_rd), .id_rm_o(m_rm),
    .id_imm12_o(m_i12), .id_imm24_o(m_i24), .fetch_count_o(m_cnt)
  );

  // ---------------- no delay slot ----------------
  logic [31:0] d_addr, d_pc, d_npc, d_instr, d_idnp, d_data;
  logic        d_v;
  logic [3:0]  d_cond, d_rn, d_rd, d_rm;
  logic [11:0] d_i12;
  logic [23:0] d_i24;
  logic [15:0] d_cnt;
  assign d_data = mem_word(d_addr[9:2]);

  fetch_stage_param #(.DELAY_SLOT(0)) u_ds0 (
    .clk_i(clk), .reset_i(rst_n), .pc_enable_i(pe), .ifid_enable_i(ie),
    .branch_taken_i(br), .branch_target_i(tgt), .flush_i(fl),
    .imem_data_i(d_data), .imem_addr_o(d_addr), .pc_o(d_pc), .next_pc_o(d_npc),
    .id_instr_o(d_instr), .id_next_pc_o(d_idnp), .id_valid_o(d_v),
    .id_cond_o(d_cond), .id_rn_o(d_rn), .id_rd_o(d_rd), .id_rm_o(d_rm),
    .id_imm12_o(d_i12), .id_imm24_o(d_i24), .fetch_count_o(d_cnt)
  );

  // ---------------- 8-bit address, 2-bit counter ----------------
  logic [7:0]  a_addr, a_pc, a_npc, a_idnp;
  logic [31:0] a_instr, a_data;
  logic        a_v;
  logic [3:0]  a_cond, a_rn, a_rd, a_rm;
  logic [11:0] a_i12;
  logic [23:0] a_i24;
  logic [1:0]  a_cnt;
  assign a_data = mem_word({2'b00, a_addr[7:2]});

  fetch_stage_param #(.ADDR_W(8), .CNT_W(2)) u_a8 (
    .clk_i(clk), .reset_i(rst_n), .pc_enable_i(pe), .ifid_enable_i(ie),
    .branch_taken_i(br), .branch_target_i(tgt[7:0]), .flush_i(fl),
    .imem_data_i(a_data), .imem_addr_o(a_addr), .pc_o(a_pc), .next_pc_o(a_npc),
    .id_instr_o(a_instr), .id_next_pc_o(a_idnp), .id_valid_o(a_v),
    .id_cond_o(a_cond), .id_rn_o(a_rn), .id_rd_o(a_rd), .id_rm_o(a_rm),
    .id_imm12_o(a_i12), .id_imm24_o(a_i24), .fetch_count_o(a_cnt)
  );

  task automatic chk(input string name, input int step, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  function automatic logic [63:0] fields_of(input logic [31:0] w);
    return {w[31:28], w[19:16], w[15:12], w[3:0], w[11:0], w[23:0]};
  endfunction

  // Drive one vector, queue its expectation, clock, then pop and compare.
  task automatic run_vec(input vec_t v, input bit is_a8, input int step);
    vec_t e;
    logic [31:0] ew;
    rst_n = v.rst_n; pe = v.pe; ie = v.ie; br = v.br; fl = v.fl; tgt = v.tgt;
    q.push_back(v);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", step, 64'd1, 64'd0);
      return;
    end
    e  = q.pop_front();
    ew = word_of(e.e_idx);
    if (!is_a8) begin
      chk("pc",       step, 64'(m_pc),    64'(e.e_pc));
      chk("next_pc",  step, 64'(m_npc),   64'(e.e_pc + 32'd4));
      chk("imem_addr",step, 64'(m_addr),  64'(e.e_pc));
      chk("valid",    step, 64'(m_v),     64'(e.e_v));
      chk("instr",    step, 64'(m_instr), 64'(ew));
      chk("id_np",    step, 64'(m_idnp),  64'(e.e_np));
      chk("count",    step, 64'(m_cnt),   64'(e.e_cnt));
      chk("fields",   step, {m_cond, m_rn, m_rd, m_rm, m_i12, m_i24}, fields_of(ew));
      chk("ds0_pc",   step, 64'(d_pc),    64'(e.e_pc));
      chk("ds0_valid",step, 64'(d_v),     64'(e.d_v));
      chk("ds0_instr",step, 64'(d_instr), 64'(word_of(e.d_idx)));
      chk("ds0_id_np",step, 64'(d_idnp),  64'(e.d_np));
      chk("ds0_count",step, 64'(d_cnt),   64'(e.d_cnt));
      chk("ds0_fields",step, {d_cond, d_rn, d_rd, d_rm, d_i12, d_i24},
          fields_of(word_of(e.d_idx)));
    end else begin
      chk("a8_pc",     step, 64'(a_pc),    64'(e.e_pc[7:0]));
      chk("a8_next_pc",step, 64'(a_npc),   64'(8'(e.e_pc[7:0] + 8'd4)));
      chk("a8_valid",  step, 64'(a_v),     64'(e.e_v));
      chk("a8_instr",  step, 64'(a_instr), 64'(ew));
      chk("a8_id_np",  step, 64'(a_idnp),  64'(e.e_np[7:0]));
      chk("a8_count",  step, 64'(a_cnt),   64'(e.e_cnt));
      chk("a8_fields", step, {a_cond, a_rn, a_rd, a_rm, a_i12, a_i24}, fields_of(ew));
    end
  endtask

  function automatic vec_t mk(input bit r, pe_, ie_, br_, fl_, input logic [31:0] t,
                              input logic [31:0] pc_, input bit v_, input int idx,
                              input logic [31:0] np_, input int cnt_);
    vec_t v;
    v.rst_n = r; v.pe = pe_; v.ie = ie_; v.br = br_; v.fl = fl_; v.tgt = t;
    v.e_pc = pc_; v.e_v = v_; v.e_idx = idx; v.e_np = np_; v.e_cnt = cnt_;
    v.d_v = v_; v.d_idx = idx; v.d_np = np_; v.d_cnt = cnt_;
    return v;
  endfunction

  function automatic vec_t ds0(input vec_t v, input bit dv, input int didx,
                               input logic [31:0] dnp, input int dcnt);
    vec_t o;
    o = v; o.d_v = dv; o.d_idx = didx; o.d_np = dnp; o.d_cnt = dcnt;
    return o;
  endfunction

  vec_t tbl [16];

  initial begin
    //            rst pe ie br fl  tgt     pc      v idx np      cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h00, 0, -1, 32'h00, 0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 32'h20, 32'h00, 0, -1, 32'h00, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 32'h0,  32'h04, 1,  0, 32'h04, 1);
    tbl[3]  = mk(1, 1, 1, 0, 0, 32'h0,  32'h08, 1,  1, 32'h08, 2);
    tbl[4]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h08, 1,  1, 32'h08, 2);
    tbl[5]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h08, 1,  1, 32'h08, 2);
    tbl[6]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h08, 1,  1, 32'h08, 2);
    tbl[7]  = mk(1, 1, 1, 0, 0, 32'h0,  32'h0C, 1,  2, 32'h0C, 3);
    tbl[8]  = mk(1, 1, 1, 0, 0, 32'h0,  32'h10, 1,  3, 32'h10, 4);
    // branch at pc=16: delay slot keeps word 4, otherwise squashed
    tbl[9]  = ds0(mk(1, 1, 1, 1, 0, 32'h40, 32'h40, 1, 4, 32'h14, 5), 0, -1, 32'h0, 4);
    tbl[10] = ds0(mk(1, 1, 1, 0, 0, 32'h0,  32'h44, 1, 16, 32'h44, 6), 1, 16, 32'h44, 5);
    // flush with both stalls: PC held, IF/ID cleared
    tbl[11] = ds0(mk(1, 0, 0, 0, 1, 32'h0,  32'h44, 0, -1, 32'h00, 6), 0, -1, 32'h0, 5);
    // PC stalled, IF/ID re-captures the same word and counts each time
    tbl[12] = ds0(mk(1, 0, 1, 0, 0, 32'h0,  32'h44, 1, 17, 32'h48, 7), 1, 17, 32'h48, 6);
    tbl[13] = ds0(mk(1, 0, 1, 0, 0, 32'h0,  32'h44, 1, 17, 32'h48, 8), 1, 17, 32'h48, 7);
    // flush overrides ifid_enable
    tbl[14] = ds0(mk(1, 1, 1, 0, 1, 32'h0,  32'h48, 0, -1, 32'h00, 8), 0, -1, 32'h0, 7);
    // reset dominates a taken branch
    tbl[15] = mk(0, 1, 1, 1, 0, 32'h80, 32'h00, 0, -1, 32'h00, 0);

    #1;
    for (int i = 0; i < 16; i++) run_vec(tbl[i], 1'b0, i);

    // 8-bit address instance: wrap at 0xFC and counter saturation at 3
    run_vec(mk(0, 0, 0, 0, 0, 32'h00, 32'h00, 0, -1, 32'h00, 0), 1'b1, 100);
    run_vec(mk(1, 1, 1, 1, 0, 32'hFC, 32'hFC, 1,  0, 32'h04, 1), 1'b1, 101);
    run_vec(mk(1, 1, 1, 0, 0, 32'h00, 32'h00, 1, 63, 32'h00, 2), 1'b1, 102);
    run_vec(mk(1, 1, 1, 0, 0, 32'h00, 32'h04, 1,  0, 32'h04, 3), 1'b1, 103);
    run_vec(mk(1, 1, 1, 0, 0, 32'h00, 32'h08, 1,  1, 32'h08, 3), 1'b1, 104);
    run_vec(mk(1, 1, 1, 0, 0, 32'h00, 32'h0C, 1,  2, 32'h0C, 3), 1'b1, 105);
    run_vec(mk(0, 1, 1, 1, 0, 32'h80, 32'h00, 0, -1, 32'h00, 0), 1'b1, 106);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
